// File: rtl/bcd_encoder_pkg.sv
`default_nettype none
//==============================================================================
// Module  : bcd_pkg
// Brief   : Shared digit width, decimal limit, digit type and legality check.
// Rev     : 1.0  initial release
//==============================================================================
package bcd_pkg;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] DEC_MAX = 4'd9;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   function automatic logic is_decimal(input bcd_digit_t digit);
      return (digit <= DEC_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_encoder_if.sv
`default_nettype none
//==============================================================================
// Module  : bcd_encoder_if
// Brief   : Digit-in / BCD-out bundle; master drives samples, slave encodes.
// Rev     : 1.0  initial release
//==============================================================================
interface bcd_encoder_if;

   bcd_pkg::bcd_digit_t decimal_input;
   logic                in_valid;
   logic                err_clr;
   bcd_pkg::bcd_digit_t bcd_output;
   logic                out_valid;
   logic                digit_err;
   logic                sticky_err;

   modport master (
      output decimal_input, in_valid, err_clr,
      input  bcd_output, out_valid, digit_err, sticky_err
   );

   modport slave (
      input  decimal_input, in_valid, err_clr,
      output bcd_output, out_valid, digit_err, sticky_err
   );

endinterface
`default_nettype wire

// File: rtl/bcd_encoder_digit_map.sv
`default_nettype none
//==============================================================================
// Module  : bcd_digit_map
// Brief   : Combinational 4-bit code to BCD digit map with illegal-code flag.
// Rev     : 1.0  initial release
//==============================================================================
module bcd_digit_map
   import bcd_pkg::*;
#(
   parameter bcd_digit_t ERR_CODE = 4'b0000
) (
   input  bcd_digit_t i_code,
   output bcd_digit_t o_digit,
   output logic       o_illegal
);

   logic w_legal;

   assign w_legal   = is_decimal(i_code);
   assign o_digit   = w_legal ? i_code : ERR_CODE;
   assign o_illegal = ~w_legal;

endmodule
`default_nettype wire

// File: rtl/bcd_encoder.sv
`default_nettype none
//==============================================================================
// Module  : bcd_encoder
// Brief   : Registered decimal-to-BCD encoder with per-sample and sticky error.
// Rev     : 1.0  initial release
//==============================================================================
module bcd_encoder
   import bcd_pkg::*;
#(
   parameter bcd_digit_t ERR_CODE = 4'b0000
) (
   input  logic          clk,
   input  logic          rst_n,
   bcd_encoder_if.slave  bus
);

   bcd_digit_t w_digit;
   logic       w_illegal;
   bcd_digit_t r_bcd;
   logic       r_valid;
   logic       r_err;
   logic       r_sticky;

   bcd_digit_map #(
      .ERR_CODE (ERR_CODE)
   ) u_map (
      .i_code    (bus.decimal_input),
      .o_digit   (w_digit),
      .o_illegal (w_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcd    <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         r_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_bcd <= w_digit;
            r_err <= w_illegal;
         end
         // A new illegal sample outranks a simultaneous clear.
         if (bus.in_valid && w_illegal) begin
            r_sticky <= 1'b1;
         end else if (bus.err_clr) begin
            r_sticky <= 1'b0;
         end
      end
   end

   assign bus.bcd_output = r_bcd;
   assign bus.out_valid  = r_valid;
   assign bus.digit_err  = r_err;
   assign bus.sticky_err = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_bcd_encoder.sv
`default_nettype none
//==============================================================================
// Module  : tb_bcd_encoder
// Brief   : Directed self-checking bench for bcd_encoder.
// Rev     : 1.0  initial release
//==============================================================================
module tb_bcd_encoder;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   bcd_encoder_if bus ();

   bcd_encoder #(
      .ERR_CODE (4'b0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] bcd, input logic vld,
                          input logic derr, input logic serr);
      chk({tag, ".bcd"},    bus.bcd_output,          bcd);
      chk({tag, ".valid"},  {3'b0, bus.out_valid},   {3'b0, vld});
      chk({tag, ".derr"},   {3'b0, bus.digit_err},   {3'b0, derr});
      chk({tag, ".sticky"}, {3'b0, bus.sticky_err},  {3'b0, serr});
   endtask

   // Inputs change on the falling edge; outputs are checked on the next falling edge.
   task automatic step(input logic [3:0] code, input logic vld, input logic clr);
      bus.decimal_input = code;
      bus.in_valid      = vld;
      bus.err_clr       = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n             = 1'b0;
      bus.decimal_input = 4'd7;
      bus.in_valid      = 1'b1;
      bus.err_clr       = 1'b0;

      // Reset held with a live input: nothing may be captured.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(4'd7, 1'b1, 1'b0);
      chk_all("first7", 4'd7, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         step(4'(i), 1'b1, 1'b0);
         chk_all($sformatf("sweep%0d", i), 4'(i), 1'b1, 1'b0, 1'b0);
      end

      for (int i = 10; i < 16; i++) begin
         step(4'(i), 1'b1, 1'b0);
         chk_all($sformatf("illegal%0d", i), 4'd0, 1'b1, 1'b1, 1'b1);
      end

      step(4'd3, 1'b1, 1'b1);
      chk_all("clr_legal", 4'd3, 1'b1, 1'b0, 1'b0);
      step(4'd12, 1'b1, 1'b1);
      chk_all("clr_vs_set", 4'd0, 1'b1, 1'b1, 1'b1);
      step(4'd14, 1'b0, 1'b0);
      chk_all("hold_err", 4'd0, 1'b0, 1'b1, 1'b1);
      step(4'd2, 1'b0, 1'b1);
      chk_all("clr_idle", 4'd0, 1'b0, 1'b1, 1'b0);

      step(4'd5, 1'b1, 1'b0);
      chk_all("gate5", 4'd5, 1'b1, 1'b0, 1'b0);
      step(4'd3, 1'b0, 1'b0);
      chk_all("gate_hold", 4'd5, 1'b0, 1'b0, 1'b0);
      step(4'd11, 1'b0, 1'b0);
      chk_all("gate_illegal_ignored", 4'd5, 1'b0, 1'b0, 1'b0);

      step(4'd13, 1'b1, 1'b0);
      chk_all("pre_rst13", 4'd0, 1'b1, 1'b1, 1'b1);
      step(4'd4, 1'b1, 1'b0);
      chk_all("stream4", 4'd4, 1'b1, 1'b0, 1'b1);
      bus.decimal_input = 4'd8;
      @(posedge clk);
      #2;
      chk_all("stream8", 4'd8, 1'b1, 1'b0, 1'b1);
      bus.decimal_input = 4'd9;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk_all("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(4'd9, 1'b0, 1'b0);
      chk_all("no_stale", 4'd0, 1'b0, 1'b0, 1'b0);
      step(4'd9, 1'b1, 1'b0);
      chk_all("post_rst9", 4'd9, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd_encoder.md
Name: bcd_encoder

Overview:
- Registered decimal-digit to BCD encoder.
- Accepts a 4-bit decimal digit code and outputs its 8421 BCD value one clock later.
- Flags non-decimal codes (10..15) on a per-sample error output and on a sticky error output.
- Sits at the front of digit-display and arithmetic paths that expect clean BCD.

Parameters:
- ERR_CODE, 4'b0000, value driven on bcd_output when the input code is non-decimal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- decimal_input  input  4  decimal digit code; legal range 0..9.
- in_valid  input  1  decimal_input is sampled only when in_valid=1.
- err_clr  input  1  synchronous clear of sticky_err.
- bcd_output  output  4  registered BCD digit.
- out_valid  output  1  bcd_output and digit_err are valid this cycle.
- digit_err  output  1  the sample in this output cycle was non-decimal.
- sticky_err  output  1  latched error; set by any non-decimal sample, held until err_clr.

Behaviour:
- Reset: asserting rst_n=0 immediately drives bcd_output=0, out_valid=0, digit_err=0 and sticky_err=0, independent of clk. Release is synchronous to the next rising edge.
- Latency is exactly 1 cycle. A sample accepted at edge N (in_valid=1) appears on the outputs after edge N, with out_valid=1 for exactly that cycle.
- Throughput is one sample per cycle. Back-to-back in_valid is fully supported with no bubbles.
- When in_valid=0:
  - out_valid goes to 0 on the next edge.
  - bcd_output and digit_err hold their last values.
- Encoding for a legal code 0..9: bcd_output equals decimal_input bit-for-bit, and digit_err=0.
- Encoding for an illegal code 10..15:
  - bcd_output=ERR_CODE and digit_err=1.
  - sticky_err is set on the same edge.
- sticky_err is cleared by err_clr=1 at an edge.
- If err_clr=1 and an illegal sample is accepted on the same edge, set wins and sticky_err stays 1.
- err_clr has no effect on bcd_output, digit_err or out_valid.
- Reset asserted mid-stream discards any in-flight sample. There is no out_valid for it after reset releases.
- Inputs sampled while rst_n=0 are ignored.
- No X propagation: every output is a flop or a constant after reset.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W=4;
  - DEC_MAX=4'd9;
  - typedef bcd_digit_t (logic [3:0]);
  - function is_decimal(digit) returning digit<=DEC_MAX.
- One combinational sub-module is natural: bcd_digit_map. It maps a 4-bit code to the BCD digit plus an illegal flag, and is reusable by multi-digit encoders.
- The top-level module holds only the output registers and the sticky flag.

Test Plan:
- Reset: hold rst_n=0 while driving decimal_input=4'd7, in_valid=1 -> all outputs 0. Release rst_n; the first edge with in_valid=1 gives bcd_output=7 and out_valid=1 one cycle later.
- Full sweep: apply 0..9 back-to-back with in_valid=1, one per cycle -> bcd_output follows 0,1,...,9 with 1-cycle lag, out_valid continuously 1, digit_err=0 and sticky_err=0 throughout.
- Illegal codes: apply 10..15 -> bcd_output=ERR_CODE (0) and digit_err=1 each cycle. sticky_err=1 from the first error onward.
- Sticky clear priority:
  - after an error, pulse err_clr with a legal input -> sticky_err=0 next cycle;
  - pulse err_clr in the same cycle as input 4'd12 -> sticky_err stays 1.
- Valid gating: drive 5 with in_valid=1, then 3 with in_valid=0 -> bcd_output=5 and out_valid=1, then bcd_output holds 5 with out_valid=0.
- Async reset mid-stream: assert rst_n=0 between edges during a stream of 4,8,9 -> outputs clear immediately with no clock edge, and no stale out_valid after release.
